// File: rtl/lsu_mem_ctrl_if.sv
// Handshake and memory-bus bundle for the load/store control stage.
// The slave view belongs to lsu_mem_ctrl; the master view belongs to the CPU/memory side.
interface lsu_mem_ctrl_if #(
    parameter int ADDR_W = 8
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_signed;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;

    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_err;

    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_we;
    logic [31:0]       mem_rdata;

    modport slave (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_wdata, mem_we
    );

    modport master (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_wdata, mem_we
    );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// Load/store control between the MEM pipeline stage and a word-wide synchronous data memory.
// Handles byte/half/word accesses, sub-word extension, read-modify-write and access errors.
module lsu_mem_ctrl #(
    parameter int ADDR_W = 8
) (
    input logic           clk,
    input logic           rst,
    lsu_mem_ctrl_if.slave bus
);

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        READ    = 3'd1,
        CAPTURE = 3'd2,
        MERGE   = 3'd3,
        WRITE   = 3'd4,
        RESP    = 3'd5
    } state_t;

    state_t            state_q,  state_d;
    logic              we_q,     we_d;
    logic [1:0]        size_q,   size_d;
    logic              signed_q, signed_d;
    logic [1:0]        lane_q,   lane_d;
    logic [ADDR_W-1:0] waddr_q,  waddr_d;
    logic [31:0]       wdata_q,  wdata_d;
    logic [31:0]       rdata_q,  rdata_d;
    logic              err_q,    err_d;

    // Misaligned, illegal-size or beyond the end of the byte-address space.
    function automatic logic access_err(input logic [31:0] addr, input logic [1:0] size);
        logic bad_range;
        logic bad_align;
        bad_range = (addr >> (ADDR_W + 2)) != 32'd0;
        case (size)
            SZ_B:    bad_align = 1'b0;
            SZ_H:    bad_align = addr[0];
            SZ_W:    bad_align = addr[1:0] != 2'b00;
            default: bad_align = 1'b1;
        endcase
        return bad_range | bad_align;
    endfunction

    function automatic logic [31:0] load_extract(input logic [31:0] word,
                                                 input logic [1:0]  size,
                                                 input logic        sgn,
                                                 input logic [1:0]  lane);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = lane[1] ? word[31:16] : word[15:0];
        case (size)
            SZ_B:    r = {{24{sgn & b[7]}}, b};
            SZ_H:    r = {{16{sgn & h[15]}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] store_merge(input logic [31:0] word,
                                                input logic [15:0] wdata,
                                                input logic [1:0]  size,
                                                input logic [1:0]  lane);
        logic [31:0] r;
        r = word;
        if (size == SZ_B) begin
            case (lane)
                2'd0:    r[7:0]   = wdata[7:0];
                2'd1:    r[15:8]  = wdata[7:0];
                2'd2:    r[23:16] = wdata[7:0];
                default: r[31:24] = wdata[7:0];
            endcase
        end else if (lane[1]) begin
            r[31:16] = wdata;
        end else begin
            r[15:0] = wdata;
        end
        return r;
    endfunction

    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        size_d   = size_q;
        signed_d = signed_q;
        lane_d   = lane_q;
        waddr_d  = waddr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    we_d     = bus.req_we;
                    size_d   = bus.req_size;
                    signed_d = bus.req_signed;
                    lane_d   = bus.req_addr[1:0];
                    waddr_d  = bus.req_addr[ADDR_W+1:2];
                    wdata_d  = bus.req_wdata;
                    rdata_d  = 32'd0;
                    err_d    = access_err(bus.req_addr, bus.req_size);
                    if (access_err(bus.req_addr, bus.req_size))
                        state_d = RESP;
                    else if (bus.req_we && bus.req_size == SZ_W)
                        state_d = WRITE;
                    else
                        state_d = READ;
                end
            end
            READ:    state_d = we_q ? MERGE : CAPTURE;
            CAPTURE: begin
                rdata_d = load_extract(bus.mem_rdata, size_q, signed_q, lane_q);
                state_d = RESP;
            end
            // The merged word replaces the store data so WRITE always drives wdata_q.
            MERGE: begin
                wdata_d = store_merge(bus.mem_rdata, wdata_q[15:0], size_q, lane_q);
                state_d = WRITE;
            end
            WRITE:   state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            we_q     <= 1'b0;
            size_q   <= 2'b00;
            signed_q <= 1'b0;
            lane_q   <= 2'b00;
            waddr_q  <= '0;
            wdata_q  <= 32'd0;
            rdata_q  <= 32'd0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            size_q   <= size_d;
            signed_q <= signed_d;
            lane_q   <= lane_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    // Outputs are gated by rst so nothing escapes while reset is held mid-operation.
    logic mem_busy;
    logic in_write;
    logic in_resp;

    assign mem_busy = ~rst & (state_q == READ || state_q == CAPTURE ||
                              state_q == MERGE || state_q == WRITE);
    assign in_write = ~rst & (state_q == WRITE);
    assign in_resp  = ~rst & (state_q == RESP);

    assign bus.req_ready  = ~rst & (state_q == IDLE);
    assign bus.resp_valid = in_resp;
    assign bus.resp_rdata = in_resp ? rdata_q : 32'd0;
    assign bus.resp_err   = in_resp & err_q;
    assign bus.mem_addr   = mem_busy ? waddr_q : '0;
    assign bus.mem_we     = in_write;
    assign bus.mem_wdata  = in_write ? wdata_q : 32'd0;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Scoreboard bench for lsu_mem_ctrl: directed requests push expected responses and
// memory writes; an independent monitor pops and compares whenever the DUT presents them.
module tb_lsu_mem_ctrl;

    localparam int ADDR_W = 8;

    logic clk = 1'b0;
    logic rst;
    int   cyc;
    int   checks;
    int   errors;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    lsu_mem_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    lsu_mem_ctrl #(.ADDR_W(ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Synchronous-read memory model: data appears the cycle after the address.
    logic [31:0] mem [256];
    logic [31:0] rdata_r;
    always @(posedge clk) begin
        if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
        rdata_r <= mem[bus.mem_addr];
    end
    assign bus.mem_rdata = rdata_r;

    typedef struct {
        int          cyc;
        logic [31:0] rdata;
        logic        err;
    } resp_t;

    typedef struct {
        int          cyc;
        logic [7:0]  addr;
        logic [31:0] data;
    } wr_t;

    resp_t rq[$];
    wr_t   wq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: samples just after the falling edge, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (bus.resp_valid) begin
                if (rq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_resp actual=rdata %h err %b required=no response (cycle %0d)",
                             bus.resp_rdata, bus.resp_err, cyc);
                end else begin
                    resp_t e;
                    e = rq.pop_front();
                    chk("resp_cycle", cyc, e.cyc);
                    chk("resp_rdata", bus.resp_rdata, e.rdata);
                    chk("resp_err", {31'd0, bus.resp_err}, {31'd0, e.err});
                end
            end else begin
                chk("idle_rdata", bus.resp_rdata, 32'd0);
                chk("idle_err", {31'd0, bus.resp_err}, 32'd0);
            end
            if (bus.mem_we) begin
                if (wq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write actual=addr %h data %h required=no write (cycle %0d)",
                             bus.mem_addr, bus.mem_wdata, cyc);
                end else begin
                    wr_t w;
                    w = wq.pop_front();
                    chk("write_cycle", cyc, w.cyc);
                    chk("write_addr", {24'd0, bus.mem_addr}, {24'd0, w.addr});
                    chk("write_data", bus.mem_wdata, w.data);
                end
            end
        end
    end

    // Called at a falling edge; returns at the falling edge right after the accept edge.
    task automatic issue(input logic we, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rdata, input logic exp_err,
                         input logic exp_wr, input logic [31:0] exp_word,
                         input int lat, input logic hold, input logic track,
                         output int acc);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_size   = size;
        bus.req_signed = sgn;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        acc = -1;
        for (int i = 0; i < 64; i++) begin
            if (bus.req_ready) begin
                acc = cyc + 1;
                break;
            end
            @(negedge clk);
        end
        if (acc < 0) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout actual=no accept required=accept of addr %h", addr);
            bus.req_valid = 1'b0;
        end else begin
            if (track) begin
                rq.push_back('{cyc: acc + lat - 1, rdata: exp_rdata, err: exp_err});
                if (exp_wr) wq.push_back('{cyc: acc + lat - 2, addr: addr[9:2], data: exp_word});
            end
            @(negedge clk);
            bus.req_we     = $urandom_range(0, 1);
            bus.req_size   = 2'($urandom_range(0, 3));
            bus.req_signed = $urandom_range(0, 1);
            bus.req_addr   = $urandom;
            bus.req_wdata  = $urandom;
            if (!hold) bus.req_valid = 1'b0;
        end
    endtask

    int acc_a;
    int acc_b;

    task automatic ld(input logic [1:0] size, input logic sgn, input logic [31:0] addr,
                      input logic [31:0] exp);
        issue(1'b0, size, sgn, addr, 32'd0, exp, 1'b0, 1'b0, 32'd0, 3, 1'b0, 1'b1, acc_a);
    endtask

    task automatic st(input logic [1:0] size, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] word);
        issue(1'b1, size, 1'b0, addr, wdata, 32'd0, 1'b0, 1'b1, word,
              (size == 2'b10) ? 2 : 4, 1'b0, 1'b1, acc_a);
    endtask

    task automatic er(input logic we, input logic [1:0] size, input logic [31:0] addr);
        issue(we, size, 1'b1, addr, 32'hA5A5A5A5, 32'd0, 1'b1, 1'b0, 32'd0, 1, 1'b0, 1'b1, acc_a);
    endtask

    initial begin
        rst            = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_size   = 2'b00;
        bus.req_signed = 1'b0;
        bus.req_addr   = 32'd0;
        bus.req_wdata  = 32'd0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd0);
        chk("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        chk("rst_mem_we", {31'd0, bus.mem_we}, 32'd0);
        chk("rst_mem_addr", {24'd0, bus.mem_addr}, 32'd0);
        chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
        chk("rst_resp_rdata", bus.resp_rdata, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", {31'd0, bus.req_ready}, 32'd1);

        st(2'b10, 32'h10, 32'hDEADBEEF, 32'hDEADBEEF);
        ld(2'b10, 1'b0, 32'h10, 32'hDEADBEEF);

        st(2'b10, 32'h10, 32'h80FF7F01, 32'h80FF7F01);
        ld(2'b00, 1'b1, 32'h13, 32'hFFFFFF80);
        ld(2'b00, 1'b0, 32'h13, 32'h00000080);
        ld(2'b01, 1'b1, 32'h10, 32'h00007F01);
        ld(2'b01, 1'b1, 32'h12, 32'hFFFF80FF);
        ld(2'b01, 1'b0, 32'h12, 32'h000080FF);
        ld(2'b00, 1'b1, 32'h10, 32'h00000001);

        st(2'b00, 32'h11, 32'h000000AA, 32'h80FFAA01);
        st(2'b01, 32'h12, 32'hABCD1234, 32'h1234AA01);
        ld(2'b10, 1'b1, 32'h10, 32'h1234AA01);

        st(2'b10, 32'h3FC, 32'h5A000000, 32'h5A000000);
        ld(2'b00, 1'b0, 32'h3FF, 32'h0000005A);

        er(1'b0, 2'b01, 32'h11);
        er(1'b1, 2'b10, 32'h12);
        er(1'b0, 2'b11, 32'h14);
        er(1'b0, 2'b10, 32'h400);
        er(1'b1, 2'b00, 32'h400);
        er(1'b1, 2'b01, 32'h13);

        // Reset while a byte store sits in WRITE: the write and response are abandoned.
        st(2'b10, 32'h20, 32'h11223344, 32'h11223344);
        issue(1'b1, 2'b00, 1'b0, 32'h20, 32'h00000055, 32'd0, 1'b0, 1'b0, 32'd0,
              4, 1'b0, 1'b0, acc_a);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rstmid_mem_we", {31'd0, bus.mem_we}, 32'd0);
        chk("rstmid_mem_addr", {24'd0, bus.mem_addr}, 32'd0);
        chk("rstmid_req_ready", {31'd0, bus.req_ready}, 32'd0);
        chk("rstmid_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rstmid_ready_after", {31'd0, bus.req_ready}, 32'd1);
        ld(2'b10, 1'b0, 32'h20, 32'h11223344);

        // Back-to-back with req_valid held: second accept waits for the IDLE after RESP.
        issue(1'b1, 2'b10, 1'b0, 32'h30, 32'hCAFEF00D, 32'd0, 1'b0, 1'b1, 32'hCAFEF00D,
              2, 1'b1, 1'b1, acc_a);
        issue(1'b0, 2'b10, 1'b0, 32'h30, 32'd0, 32'hCAFEF00D, 1'b0, 1'b0, 32'd0,
              3, 1'b0, 1'b1, acc_b);
        chk("b2b_accept_cycle", acc_b, acc_a + 3);

        for (int i = 0; i < 100; i++) begin
            if (rq.size() == 0 && wq.size() == 0) break;
            @(negedge clk);
        end
        repeat (4) @(negedge clk);
        if (rq.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL missing_resp actual=%0d outstanding required=0", rq.size());
        end
        if (wq.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL missing_write actual=%0d outstanding required=0", wq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
- Load/store control stage between the CPU MEM pipeline stage and the 256x32 word-wide data memory.
- Accepts byte, halfword and word load/store requests over a valid/ready handshake.
- Performs sub-word extraction with sign or zero extension, and read-modify-write for byte and half stores.
- Flags misaligned and out-of-range accesses without touching memory, and returns one response per request.

Parameters:
- ADDR_W, 8, word-address width of the data memory. Byte-address space is 4<<ADDR_W bytes (0x400 at the default).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- req_valid  input  1  request present
- req_ready  output  1  block can accept a request
- req_we  input  1  1 = store, 0 = load
- req_size  input  2  00 byte, 01 half, 10 word, 11 illegal
- req_signed  input  1  sign-extend sub-word loads (lb/lh); 0 = lbu/lhu
- req_addr  input  32  byte address
- req_wdata  input  32  store data, right-aligned
- resp_valid  output  1  one-cycle response strobe
- resp_rdata  output  32  load result; 0 for stores and errors
- resp_err  output  1  misaligned/illegal/out-of-range, valid with resp_valid
- mem_addr  output  ADDR_W  word address to data memory, = addr[ADDR_W+1:2]
- mem_wdata  output  32  write data to memory
- mem_we  output  1  memory write enable
- mem_rdata  input  32  memory read data, valid the cycle after mem_addr is presented with mem_we=0

Behaviour:
- Reset: on a clk edge with rst=1, state -> IDLE and all request registers clear.
  - While rst=1: req_ready=0, resp_valid=0, resp_err=0, resp_rdata=0, mem_we=0 (gated by rst), mem_addr=0, mem_wdata=0.
  - Reset mid-operation abandons the request: no write, no response.
- States: IDLE, READ, CAPTURE, MERGE, WRITE, RESP.
- req_ready=1 only in IDLE with rst=0. Handshake fires when req_valid&req_ready at a clk edge; the request is latched on that edge.
- Error check at accept; an error goes IDLE->RESP with resp_err=1 and no memory access. Error conditions:
  - size==11
  - size==01 with addr[0]=1
  - size==10 with addr[1:0]!=0
  - addr >= 4<<ADDR_W
- Word store: IDLE->WRITE->RESP.
  - In WRITE: mem_we=1, mem_wdata=req_wdata.
- Load: IDLE->READ->CAPTURE->RESP.
  - READ presents mem_addr with mem_we=0.
  - CAPTURE registers the extracted result from mem_rdata.
- Byte/half store: IDLE->READ->MERGE->WRITE->RESP.
  - MERGE registers mem_rdata with the addressed lane(s) replaced by req_wdata[7:0] or [15:0].
  - WRITE writes the merged word.
- Lanes are little-endian: byte n = bits [8n+7:8n]. Half at addr[1]=0 -> [15:0]; addr[1]=1 -> [31:16].
- Load extraction:
  - lb/lh: replicate the top bit of the lane.
  - lbu/lhu: zero-fill.
  - lw: full word.
- Latency from the accept edge k:
  - error: resp_valid in cycle k+1
  - sw: k+2
  - load: k+3
  - sb/sh: k+4
- RESP lasts exactly one cycle, then IDLE. The next request can be accepted on the edge ending RESP+1 (IDLE cycle).
- mem_addr holds the latched word address in READ/CAPTURE/MERGE/WRITE, and 0 otherwise. mem_we=1 only in WRITE.
- resp_rdata/resp_err are 0 whenever resp_valid=0.
- req_* inputs are ignored outside the handshake; changes after accept have no effect.

Test Plan:
- Reset with FSM in WRITE (sb in flight) -> mem_we=0 in the reset cycle, memory word unchanged, req_ready=1 the cycle after rst falls, no resp_valid.
- sw addr 0x10 data 0xDEADBEEF -> mem_we=1 at k+1 with mem_addr=0x04; resp_valid at k+2 with resp_err=0. Then lw 0x10 -> resp_rdata=0xDEADBEEF at k+3.
- With word 0x10 = 0x80FF7F01:
  - lb 0x13 -> 0xFFFFFF80
  - lbu 0x13 -> 0x00000080
  - lh 0x10 -> 0x00007F01
  - lh 0x12 -> 0xFFFF80FF
  - lhu 0x12 -> 0x000080FF
- sb 0x11 data 0x000000AA onto word 0x80FF7F01 -> written word 0x80FFAA01 at k+3, resp at k+4. sh 0x12 data 0x1234 -> 0x1234AA01.
- Errors:
  - lh 0x11, sw 0x12, size 11, and lw 0x400 each -> resp_valid with resp_err=1 at k+1, resp_rdata=0, mem_we never asserted.
- Back-to-back req_valid held high with sw then lw -> second accept occurs only in the IDLE cycle after RESP; req_ready=0 in all other states.
